xor_parity_acc: RTL

Parametrised, clocked successor to the two-input XOR gate: accumulates XOR parity over a stream of WIDTH-bit words grouped into frames. For each frame it outputs column parity (bitwise XOR of all words), row parity (XOR of all bits, even or odd sense) and a beat count. It sits between a word source and a consumer, using valid/ready handshakes on both sides, and serves as the team's reusable parity generator/checker.

---
 rtl/xor_parity_acc.sv | 105 ++++++++++
 1 files changed

// File: rtl/xor_parity_acc.sv
// xor_parity_acc
//   Accumulates XOR parity over frames of WIDTH-bit words. For each frame it
//   reports the column parity (bitwise XOR of every accepted word), the row
//   parity (reduction XOR of the column parity, inverted when ODD=1), the
//   number of accepted beats (saturating at MAX_LEN) and an overflow flag.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input word valid
//   in_ready   block can accept a word (low while a result is held)
//   in_data    input word
//   in_last    final word of the frame
//   out_valid  frame result valid
//   out_ready  consumer accepts the result
//   out_col    XOR of all accepted words in the frame
//   out_row    reduction XOR of out_col, XOR ODD
//   out_count  accepted beats in the frame, saturating at MAX_LEN
//   out_ovf    frame carried more than MAX_LEN beats
module xor_parity_acc #(
  parameter int WIDTH   = 8,
  parameter int ODD     = 0,
  parameter int MAX_LEN = 16,
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_col,
  output logic             out_row,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             beat;
  logic             at_max;

  // Beat counter increment that sticks at MAX_LEN.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c == CNT_MAX) return c;
    return c + 1'b1;
  endfunction

  assign in_ready  = (state != S_HOLD);
  assign out_valid = (state == S_HOLD);
  assign beat      = in_valid && in_ready;
  // A beat arriving with the counter already full means the frame is too long.
  assign at_max    = (cnt == CNT_MAX);
  assign out_row   = (^out_col) ^ 1'(ODD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_col   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACC: begin
          if (beat) begin
            if (in_last) begin
              // Fold the final word straight into the result and clear the
              // accumulator so the next frame starts clean.
              out_col   <= acc ^ in_data;
              out_count <= sat_inc(cnt);
              out_ovf   <= ovf | at_max;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= S_HOLD;
            end else begin
              acc   <= acc ^ in_data;
              cnt   <= sat_inc(cnt);
              ovf   <= ovf | at_max;
              state <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
